// File: rtl/apb_master.sv
// APB master bridge: turns a single valid/ready command into one APB
// transfer (SETUP then ACCESS) and returns the result on a valid/ready
// response channel. An ACCESS phase that waits too long is aborted and
// reported as a timeout error.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB
  output logic [DATA_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // The wait counter holds the number of PREADY-low ACCESS cycles already
  // seen; the abort fires on the cycle that would make it TIMEOUT_CYCLES.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q,       state_d;
  logic [7:0]            wait_cnt_q,    wait_cnt_d;
  logic [DATA_WIDTH-1:0] paddr_q,       paddr_d;
  logic                  pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  // Next-state and next-output logic; every registered output is computed
  // one cycle ahead so that it lines up with the state it belongs to.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        // single SETUP cycle; counter starts fresh for this ACCESS phase
        penable_d  = 1'b1;
        wait_cnt_d = 8'd0;
        state_d    = S_ACCESS;
      end

      S_ACCESS: begin
        if (PREADY) begin
          // completion wins over a timeout landing in the same cycle
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          wait_cnt_d    = 8'(wait_cnt_q + 8'd1);
          state_d       = S_RESP;
        end else begin
          wait_cnt_d = 8'(wait_cnt_q + 8'd1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including an
  // in-flight transfer, which is dropped without a response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 8'd0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // cmd_ready is the only combinational output: accept only when idle.
  assign cmd_ready   = (state_q == S_IDLE);

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: table of transfers with hand-computed expected
// responses pushed to a scoreboard queue when the command is issued and
// popped when the response handshake happens; plus reset sequences.
module tb_apb_master;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [DW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;
  logic          PSLVERR = 1'b0;

  apb_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    logic          slverr;
    int            waits;      // PREADY raised on ACCESS cycle waits+1
    int            hold;       // cycles of rsp_ready=0 before accepting
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_access; // expected number of ACCESS cycles
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  vec_t vecs[8];
  rsp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    rsp_t exp_r;
    rsp_t got;
    int   access;
    int   iters;
    bit   done;
    bit   stable_ok;

    // issue command (cycle N; accepted at the following edge)
    @(negedge PCLK);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    exp_r.rdata = v.exp_rdata;
    exp_r.err   = v.exp_err;
    exp_r.to    = v.exp_to;
    exp_q.push_back(exp_r);

    // SETUP cycle N+1
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk("setup_sel_en", {PSEL, PENABLE, cmd_ready}, 3'b100);
    chk("setup_addr_wr_data", {PADDR, PWRITE, PWDATA}, {v.addr, v.wr, v.wdata});

    // ACCESS cycles
    @(negedge PCLK);
    access = 0;
    iters = 0;
    done = 0;
    stable_ok = 1;
    while (!done && iters < 40) begin
      if (PSEL && PENABLE) access++;
      if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata) stable_ok = 0;
      if (access == v.waits + 1) begin
        PREADY  = 1'b1;
        PRDATA  = v.prdata;
        PSLVERR = v.slverr;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'b1;
      end
      @(negedge PCLK);
      iters++;
      if (rsp_valid) done = 1;
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    chk("rsp_seen_in_bound", done, 1'b1);
    chk("access_cycles", access, v.exp_access);
    chk("access_stable", stable_ok, 1'b1);
    chk("latency", 2 + iters, 2 + v.exp_access);
    chk("resp_sel_en", {PSEL, PENABLE}, 2'b00);

    // backpressure: response must hold; a second command must be ignored
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      cmd_write = ~v.wr;
      cmd_addr  = 32'hBAD0_0000;
      cmd_wdata = 32'h0BAD_0BAD;
      chk("hold_valid_ready", {rsp_valid, cmd_ready, PSEL}, 3'b100);
      chk("hold_rsp_stable", {rsp_rdata, rsp_err, rsp_timeout},
          {exp_q[0].rdata, exp_q[0].err, exp_q[0].to});
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;

    // response handshake
    chk("rsp_valid", rsp_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      exp_r = exp_q.pop_front();
      got.rdata = rsp_rdata;
      got.err   = rsp_err;
      got.to    = rsp_timeout;
      chk("rsp_fields", got, exp_r);
      $display("txn %0d: wr=%0d addr=%08h rdata=%08h err=%0d to=%0d access=%0d",
               idx, v.wr, v.addr, got.rdata, got.err, got.to, access);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("back_to_idle", {rsp_valid, cmd_ready, PSEL, PENABLE}, 4'b0100);
    chk("addr_held", {PADDR, PWRITE, PWDATA}, {v.addr, v.wr, v.wdata});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr    addr          wdata         prdata        err  wt  hd  exp_rdata     e     t     acc
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, 0,  0, 32'h0000_0000, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h1111_1111, 32'h1234_5678, 1'b0, 3,  0, 32'h1234_5678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_0001, 1'b1, 0,  0, 32'hCAFE_0001, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         32'h7777_7777, 1'b0, 99, 0, 32'h0000_0000, 1'b1, 1'b1, 4};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'h2222_2222, 32'hA5A5_A5A5, 1'b0, 3,  5, 32'hA5A5_A5A5, 1'b0, 1'b0, 4};
    vecs[5] = '{1'b1, 32'h0000_0050, 32'h0BAD_F00D, 32'h3333_3333, 1'b1, 2,  0, 32'h0000_0000, 1'b1, 1'b0, 3};
    vecs[6] = '{1'b1, 32'h0000_0060, 32'h6666_6666, 32'h4444_4444, 1'b0, 99, 2, 32'h0000_0000, 1'b1, 1'b1, 4};
    vecs[7] = '{1'b0, 32'h0000_0070, 32'h0,         32'h5A5A_0F0F, 1'b0, 1,  0, 32'h5A5A_0F0F, 1'b0, 1'b0, 2};

    // reset state, with junk on the inputs to show reset priority
    cmd_valid = 1'b1;
    cmd_addr  = 32'hFFFF_FFFF;
    PREADY    = 1'b1;
    PRDATA    = 32'hFFFF_FFFF;
    PSLVERR   = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("reset_ctrl", {cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, rsp_err, rsp_timeout}, 7'b1000000);
    chk("reset_data", {PADDR, PWDATA, rsp_rdata}, 96'h0);
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRESET    = 1'b0;
    @(negedge PCLK);
    chk("post_reset_idle", {cmd_ready, PSEL, PENABLE, rsp_valid}, 4'b1000);

    for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

    // reset while in ACCESS: transfer dropped, no response
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_2000;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    PRDATA = 32'h9999_9999;
    PREADY = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b0;
    chk("mid_reset_outs", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    chk("mid_reset_addr", PADDR, 32'h0);
    @(negedge PCLK);
    chk("mid_reset_no_rsp", {rsp_valid, PSEL, cmd_ready}, 3'b001);
    $display("txn reset: transfer at 2000 aborted by reset");
    do_txn(8, vecs[0]);
    do_txn(9, vecs[7]);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
